// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load or store per handshake and returns
// each load after LATENCY cycles as a one-cycle valid pulse with the echoed address.
module dmem_responder #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 20,
    parameter int NUM_BYTES       = DATA_WIDTH / 8,
    parameter int INDEX_BITS      = 10,
    parameter int LATENCY         = 2,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    store,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_BYTES-1:0]    byte_en,
    output logic                    ready,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [ADDRESS_BITS-1:0] address_out,
    input  logic                    scan
);

    localparam int unsigned LOG2_NUM_BYTES = $clog2(NUM_BYTES);
    localparam int unsigned DEPTH          = 1 << INDEX_BITS;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned CYC_W          = 32;
    localparam logic [CNT_W-1:0] WAIT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [INDEX_BITS-1:0]   index;
    logic                    accept, accept_load, accept_store;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   pend_data_q, data_q;
    logic [ADDRESS_BITS-1:0] pend_addr_q, addr_q;
    logic [CYC_W-1:0]        cycle_q;

    assign index        = address[LOG2_NUM_BYTES +: INDEX_BITS];
    assign ready        = ((state_q == S_IDLE) || (state_q == S_RESP)) && !reset;
    assign accept       = ready && (load || store);
    assign accept_load  = accept && load;
    assign accept_store = accept && store;
    assign valid        = (state_q == S_RESP);
    assign data_out     = data_q;
    assign address_out  = addr_q;

    // Read word as it will look after a simultaneous store lands.
    always_comb begin
        rd_word = mem[index];
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (store && byte_en[i]) begin
                rd_word[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept_store) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (byte_en[i]) begin
                    mem[index][8*i +: 8] <= in_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept_load) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        count_d = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (count_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers only change when a response is launched, so they hold afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            pend_data_q <= '0;
            pend_addr_q <= '0;
            data_q      <= '0;
            addr_q      <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept_load) begin
                pend_data_q <= rd_word;
                pend_addr_q <= address;
            end
            if (state_d == S_RESP) begin
                data_q <= accept_load ? rd_word : pend_data_q;
                addr_q <= accept_load ? address : pend_addr_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + CYC_W'(1);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (scan && (cycle_q >= CYC_W'(SCAN_CYCLES_MIN)) && (cycle_q <= CYC_W'(SCAN_CYCLES_MAX))) begin
            $display("dmem[%0d] cycle %0d: state=%s ready=%b valid=%b address_out=0x%h data_out=0x%h",
                     CORE, cycle_q, state_q.name(), ready, valid, addr_q, data_q);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) with a per-instance
// response scoreboard checking data, echoed address and arrival time.
module tb_dmem_responder;

    localparam int unsigned NU = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ld   [NU];
    logic        st   [NU];
    logic [19:0] addr [NU];
    logic [31:0] din  [NU];
    logic [3:0]  be   [NU];
    logic        rdy  [NU];
    logic        vld  [NU];
    logic [31:0] dout [NU];
    logic [19:0] aout [NU];

    typedef struct {
        logic [31:0] data;
        logic [19:0] addr;
        longint      due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    dmem_responder #(.LATENCY(2)) u_l2 (
        .clock(clock), .reset(reset), .load(ld[0]), .store(st[0]), .address(addr[0]),
        .in_data(din[0]), .byte_en(be[0]), .ready(rdy[0]), .valid(vld[0]),
        .data_out(dout[0]), .address_out(aout[0]), .scan(1'b0));

    dmem_responder #(.LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset), .load(ld[1]), .store(st[1]), .address(addr[1]),
        .in_data(din[1]), .byte_en(be[1]), .ready(rdy[1]), .valid(vld[1]),
        .data_out(dout[1]), .address_out(aout[1]), .scan(1'b0));

    dmem_responder #(.LATENCY(4)) u_l4 (
        .clock(clock), .reset(reset), .load(ld[2]), .store(st[2]), .address(addr[2]),
        .in_data(din[2]), .byte_en(be[2]), .ready(rdy[2]), .valid(vld[2]),
        .data_out(dout[2]), .address_out(aout[2]), .scan(1'b0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
    endfunction

    task automatic push_exp(input int u, input exp_t e);
        case (u)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called at a falling edge; waits (bounded) for ready, drives one request for one edge.
    task automatic do_req(input int u, input bit l, input bit s, input logic [19:0] a,
                          input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_data);
        exp_t e;
        int   n = 0;
        while (!rdy[u] && n < 16) begin
            @(negedge clock);
            n++;
        end
        if (!rdy[u]) begin
            check($sformatf("u%0d_ready_timeout", u), 32'(rdy[u]), 32'd1);
            return;
        end
        ld[u] = l; st[u] = s; addr[u] = a; din[u] = d; be[u] = b;
        @(posedge clock);
        if (l) begin
            e.data = exp_data;
            e.addr = a;
            e.due  = longint'($time) + longint'((lat_of(u) - 1) * 10 + 5);
            push_exp(u, e);
        end
        @(negedge clock);
        ld[u] = 1'b0;
        st[u] = 1'b0;
    endtask

    task automatic mon(input int u);
        exp_t e;
        bit   have = 1'b0;
        case (u)
            0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            check($sformatf("u%0d_unexpected_valid", u), 32'(vld[u]), 32'd0);
            return;
        end
        check($sformatf("u%0d_data", u), dout[u], e.data);
        check($sformatf("u%0d_addr", u), 32'(aout[u]), 32'(e.addr));
        check($sformatf("u%0d_valid_time", u), 32'(longint'($time)), 32'(e.due));
    endtask

    always @(negedge clock) begin
        for (int u = 0; u < NU; u++) begin
            if (vld[u] === 1'b1) mon(u);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    logic [31:0] l1_data [3];

    initial begin
        reset = 1'b1;
        for (int u = 0; u < NU; u++) begin
            ld[u] = 1'b1; st[u] = 1'b0; addr[u] = '0; din[u] = '0; be[u] = '0;
        end
        repeat (3) begin
            @(negedge clock);
            for (int u = 0; u < NU; u++) begin
                check($sformatf("u%0d_rst_ready", u), 32'(rdy[u]), 32'd0);
                check($sformatf("u%0d_rst_valid", u), 32'(vld[u]), 32'd0);
                check($sformatf("u%0d_rst_data", u), dout[u], 32'd0);
            end
        end
        reset = 1'b0;
        for (int u = 0; u < NU; u++) ld[u] = 1'b0;
        @(negedge clock);
        for (int u = 0; u < NU; u++) check($sformatf("u%0d_ready_after_reset", u), 32'(rdy[u]), 32'd1);

        // LATENCY=2: store/load, one wait cycle, then RESP with ready back up.
        do_req(0, 1'b0, 1'b1, 20'h00040, 32'hDEADBEEF, 4'hF, 32'h0);
        do_req(0, 1'b1, 1'b0, 20'h00040, 32'h0, 4'h0, 32'hDEADBEEF);
        check("l2_ready_in_wait", 32'(rdy[0]), 32'd0);
        @(negedge clock);
        check("l2_ready_in_resp", 32'(rdy[0]), 32'd1);
        // Byte lanes, address wrap, load restarted from RESP.
        do_req(0, 1'b0, 1'b1, 20'h00010, 32'h11223344, 4'hF, 32'h0);
        do_req(0, 1'b0, 1'b1, 20'h00010, 32'hAABBCCDD, 4'b0101, 32'h0);
        do_req(0, 1'b1, 1'b0, 20'h00010, 32'h0, 4'h0, 32'h11BB33DD);
        do_req(0, 1'b0, 1'b1, 20'h00000, 32'h00000005, 4'hF, 32'h0);
        do_req(0, 1'b1, 1'b0, 20'h01000, 32'h0, 4'h0, 32'h00000005);
        do_req(0, 1'b1, 1'b0, 20'h00040, 32'h0, 4'h0, 32'hDEADBEEF);
        // Simultaneous load+store returns the merged word; empty byte_en writes nothing.
        do_req(0, 1'b0, 1'b1, 20'h00020, 32'h01020304, 4'hF, 32'h0);
        do_req(0, 1'b1, 1'b1, 20'h00022, 32'hCAFEF00D, 4'b0011, 32'h0102F00D);
        do_req(0, 1'b0, 1'b1, 20'h00040, 32'hFFFFFFFF, 4'h0, 32'h0);
        do_req(0, 1'b1, 1'b0, 20'h00043, 32'h0, 4'h0, 32'hDEADBEEF);
        repeat (4) @(negedge clock);
        check("l2_held_data", dout[0], 32'hDEADBEEF);
        check("l2_held_addr", 32'(aout[0]), 32'h00043);

        // LATENCY=1: back-to-back loads with ready held high.
        l1_data[0] = 32'h11110000;
        l1_data[1] = 32'h22220004;
        l1_data[2] = 32'h33330008;
        for (int i = 0; i < 3; i++) do_req(1, 1'b0, 1'b1, 20'(4 * i), l1_data[i], 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("l1_ready_%0d", i), 32'(rdy[1]), 32'd1);
            do_req(1, 1'b1, 1'b0, 20'(4 * i), 32'h0, 4'h0, l1_data[i]);
        end
        check("l1_ready_after", 32'(rdy[1]), 32'd1);
        repeat (3) @(negedge clock);

        // LATENCY=4: reset two cycles after accept drops the load; memory survives.
        do_req(2, 1'b0, 1'b1, 20'h00008, 32'h0BADCAFE, 4'hF, 32'h0);
        do_req(2, 1'b1, 1'b0, 20'h00008, 32'h0, 4'h0, 32'h0BADCAFE);
        @(negedge clock);
        reset = 1'b1;
        q2.delete();
        @(negedge clock);
        check("l4_ready_in_reset", 32'(rdy[2]), 32'd0);
        check("l2_data_cleared", dout[0], 32'h0);
        check("l2_addr_cleared", 32'(aout[0]), 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("l4_no_valid_data", dout[2], 32'h0);
        do_req(2, 1'b1, 1'b0, 20'h00008, 32'h0, 4'h0, 32'h0BADCAFE);
        repeat (6) @(negedge clock);

        check("u0_pending", 32'(q0.size()), 32'd0);
        check("u1_pending", 32'(q1.size()), 32'd0);
        check("u2_pending", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
